debug_bus_tx: RTL and testbench
===============================

# debug_bus_tx

Serializes a wide datapath debug snapshot into a byte stream for the UART transmitter. It sits between the debug unit and the UART `tx` side. On a start request it captures the snapshot bus into a shadow register, then hands one byte at a time to the UART using the `tx_start`/`tx_done` handshake, MSB byte first. It gives the debug link a self-contained transmit path that mirrors the byte-reception path.

## Interface
- `BUS_W`, default 1624: snapshot width in bits; any value ≥ 1.
- `N_BYTES`, default ceil(BUS_W/8) (derived, not overridden): number of bytes sent per dump.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset. Asynchronous and active-low.
- `start`, input, 1: dump request, sampled each cycle; honoured only in IDLE.
- `bus`, input, BUS_W: snapshot source; sampled only on the accepting cycle.
- `tx_done`, input, 1: one-cycle pulse from the UART when the current byte has been shifted out.
- `tx_start`, output, 1: one-cycle pulse launching `tx_data` into the UART.
- `tx_data`, output, 8: byte being sent. Registered and held stable from the `tx_start` cycle until the cycle after `tx_done`.
- `busy`, output, 1: high from the cycle after acceptance through the DONE cycle.
- `done`, output, 1: one-cycle pulse after the last byte's `tx_done`.

## Operation
- Shadow register: 8·N_BYTES bits, loaded with `bus` zero-extended at the MSB end. Byte i is bits [8·N_BYTES−1−8i : 8·N_BYTES−8−8i], so byte 0 goes first.
- Byte counter: counts 0..N_BYTES−1. Width is clog2(N_BYTES), minimum 1.
- FSM states:
  - IDLE: if `start` is high, load the shadow, clear the counter, go to SEND.
  - SEND: `tx_start`=1, `tx_data`=byte[counter]; go to WAIT unconditionally.
  - WAIT: `tx_start`=0. On `tx_done`: if counter = N_BYTES−1, go to DONE; otherwise increment the counter and go to SEND.
  - DONE: `done`=1; go to IDLE.
- `start` is ignored in SEND, WAIT and DONE. The shadow register is never reloaded mid-dump, so changes on `bus` during a dump have no effect.
- `tx_done` is ignored outside WAIT, including a `tx_done` arriving in the SEND cycle itself.
- All outputs are registered; none is combinational from an input.

## Timing
- Reset (asynchronous assert, `rst`=0): state IDLE, `tx_start`=0, `tx_data`=8'h00, `busy`=0, `done`=0, counter=0, shadow=0. Reset deassertion is synchronous to `clk` in use.
- Reset mid-dump: abort immediately, with no further `tx_start`. After release, the block is in IDLE with all outputs at reset values.
- Start latency: `start` sampled high at edge k gives `tx_start`=1, `busy`=1 and byte 0 during cycle k+1.
- Inter-byte gap: `tx_done` sampled in WAIT at edge t gives the next `tx_start` in cycle t+1. This is one bubble cycle, because WAIT is entered after SEND.
- Completion: the last `tx_done` at edge t gives `done`=1 and `busy`=1 in cycle t+1, then `busy`=0 in cycle t+2. A `start` in cycle t+2 is accepted.
- Total dump length: N_BYTES `tx_start` pulses, exactly one per byte. Back-to-back dumps need one IDLE cycle between them.

## Test plan
- Basic dump, BUS_W=20, `bus`=20'hABCDE, UART model asserts `tx_done` 5 cycles after each `tx_start`:
  - required bytes 8'h0A, 8'hBC, 8'hDE in that order, 3 `tx_start` pulses, one `done` pulse;
  - `busy` falls one cycle after `done`.
- Snapshot isolation: change `bus` to 20'h12345 one cycle after `start` -> the stream is still 0A, BC, DE.
- Ignored inputs:
  - `start` pulsed while in WAIT -> no restart, byte order unchanged;
  - spurious `tx_done` in IDLE and in the SEND cycle -> no counter advance and no extra `tx_start`.
- Reset mid-dump: assert `rst`=0 asynchronously after byte 1's `tx_start` -> outputs go to 0 without waiting for an edge. After release and a new `start` with `bus`=20'h00001, the stream is 00, 00, 01.
- Default width: BUS_W=1624, `bus` with byte value equal to its index mod 256 (byte 0 = 8'h00) -> 203 bytes 00, 01, …, CA; `done` only after the 203rd `tx_done`.
- Boundaries:
  - BUS_W=8, `bus`=8'hFF -> exactly one byte FF, `done` one cycle after its `tx_done`;
  - `start` held high continuously -> a new dump begins one cycle after each `busy` falls.

Source files
------------

// File: rtl/debug_bus_tx.sv
// rtl/debug_bus_tx.sv - serializes a wide debug snapshot into a UART byte stream, MSB byte first
module debug_bus_tx #(
  parameter int BUS_W = 1624
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BUS_W-1:0] bus,
  input  logic             tx_done,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             done
);

  localparam int N_BYTES = (BUS_W + 7) / 8;
  localparam int SH_W    = 8 * N_BYTES;
  localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    DONE
  } state_e;

  state_e           state_q;
  logic [SH_W-1:0]  shadow_q;
  logic [SH_W-1:0]  shadow_d;
  logic [SH_W-1:0]  bus_ext;
  logic [CNT_W-1:0] cnt_q;
  logic             tx_start_q;
  logic [7:0]       tx_data_q;
  logic             busy_q;
  logic             done_q;

  // Zero-extend the snapshot at the MSB end; the shadow shifts left one byte per
  // advance so the byte to send next is always in its top 8 bits, which avoids a
  // wide counter-indexed mux.
  always_comb begin
    bus_ext  = SH_W'(bus);
    shadow_d = shadow_q << 8;
  end

  // Dump sequencer: all outputs are registered alongside the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shadow_q   <= bus_ext;
            cnt_q      <= '0;
            tx_data_q  <= bus_ext[SH_W-1 -: 8];
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          tx_start_q <= 1'b0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            if (cnt_q == LAST_CNT) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q      <= cnt_q + 1'b1;
              shadow_q   <= shadow_d;
              tx_data_q  <= shadow_d[SH_W-1 -: 8];
              tx_start_q <= 1'b1;
              state_q    <= SEND;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_debug_bus_tx.sv
// tb/tb_debug_bus_tx.sv - bench for debug_bus_tx at widths 20, 1624 and 8
module tb_debug_bus_tx;

  logic clk = 1'b0;
  logic rst;
  logic [2:0]       start_w;
  logic [2:0]       tx_done_w;
  logic [2:0]       tx_start_w;
  logic [2:0][7:0]  tx_data_w;
  logic [2:0]       busy_w;
  logic [2:0]       done_w;
  logic [2:0]       resp;
  logic [2:0]       spur;
  logic [19:0]      bus_a;
  logic [1623:0]    bus_b;
  logic [7:0]       bus_c;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  logic [1623:0] mval [3];
  logic [7:0]    cap [3][256];
  logic [7:0]    held [3];
  logic          in_byte [3];
  logic          prev_busy [3];
  int n_start [3], n_done [3], dly [3], cd [3];
  int first_cyc [3], last_start [3], last_resp [3], done_cyc [3], fall_cyc [3];

  assign tx_done_w = resp | spur;

  debug_bus_tx #(.BUS_W(20)) dut_a (
    .clk(clk), .rst(rst), .start(start_w[0]), .bus(bus_a), .tx_done(tx_done_w[0]),
    .tx_start(tx_start_w[0]), .tx_data(tx_data_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );
  debug_bus_tx dut_b (
    .clk(clk), .rst(rst), .start(start_w[1]), .bus(bus_b), .tx_done(tx_done_w[1]),
    .tx_start(tx_start_w[1]), .tx_data(tx_data_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );
  debug_bus_tx #(.BUS_W(8)) dut_c (
    .clk(clk), .rst(rst), .start(start_w[2]), .bus(bus_c), .tx_done(tx_done_w[2]),
    .tx_start(tx_start_w[2]), .tx_data(tx_data_w[2]), .busy(busy_w[2]), .done(done_w[2])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nb(input int k);
    return (k == 0) ? 3 : (k == 1) ? 203 : 1;
  endfunction

  // Byte i of a dump is the i-th byte counted from the MSB end of the zero-extended value
  function automatic logic [7:0] exp_byte(input int k, input int i);
    return 8'(mval[k] >> (8 * (nb(k) - 1 - i)));
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_bus(input int k, input logic [1623:0] v);
    case (k)
      0: bus_a = v[19:0];
      1: bus_b = v;
      default: bus_c = v[7:0];
    endcase
  endtask

  // Monitor plus UART model: records each byte launch and answers it with tx_done after dly cycles
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (tx_start_w[k]) begin
        if (!prev_busy[k]) first_cyc[k] = cyc;
        else chk("inter_byte_gap", cyc, last_resp[k] + 1);
        chk("busy_during_start", busy_w[k], 1'b1);
        if (n_start[k] < 256) cap[k][n_start[k]] = tx_data_w[k];
        n_start[k]++;
        held[k] = tx_data_w[k];
        in_byte[k] = 1'b1;
        last_start[k] = cyc;
      end else if (in_byte[k] && rst) begin
        chk("tx_data_hold", tx_data_w[k], held[k]);
      end
      if (done_w[k]) begin
        n_done[k]++;
        done_cyc[k] = cyc;
      end
      if (prev_busy[k] && !busy_w[k]) fall_cyc[k] = cyc;
      prev_busy[k] = busy_w[k];
      resp[k] = 1'b0;
      if (!rst) begin
        cd[k] = 0;
        in_byte[k] = 1'b0;
      end else begin
        if (cd[k] > 0) begin
          cd[k]--;
          if (cd[k] == 0) resp[k] = 1'b1;
        end
        if (tx_start_w[k]) cd[k] = dly[k];
      end
      if (resp[k]) begin
        last_resp[k] = cyc;
        in_byte[k] = 1'b0;
      end
    end
  end

  // opt bit0: change bus one cycle after start; bit1: pulse start in WAIT; bit2: tx_done in SEND cycle
  task automatic dump(input int k, input logic [1623:0] v, input int d, input int opt);
    int st;
    n_start[k] = 0; n_done[k] = 0;
    first_cyc[k] = -1; done_cyc[k] = -1; fall_cyc[k] = -1;
    dly[k] = d; mval[k] = v; set_bus(k, v);
    start_w[k] = 1'b1; st = cyc; step(); start_w[k] = 1'b0;
    if (opt[2]) spur[k] = 1'b1;
    if (opt[0]) set_bus(k, 1624'h12345);
    step(); spur[k] = 1'b0;
    if (opt[1]) begin
      step(); start_w[k] = 1'b1; step(); start_w[k] = 1'b0;
    end
    for (int i = 0; i < 6000 && n_done[k] == 0; i++) step();
    repeat (3) step();
    chk("tx_start_count", n_start[k], nb(k));
    for (int i = 0; i < nb(k) && i < 256; i++) chk($sformatf("byte%0d", i), cap[k][i], exp_byte(k, i));
    chk("done_count", n_done[k], 1);
    chk("start_latency", first_cyc[k], st + 1);
    chk("done_latency", done_cyc[k], last_resp[k] + 1);
    chk("busy_fall", fall_cyc[k], done_cyc[k] + 1);
  endtask

  initial begin
    logic [1623:0] v;
    int pf;
    rst = 1'b0; start_w = '0; spur = '0;
    bus_a = '0; bus_b = '0; bus_c = '0;
    for (int k = 0; k < 3; k++) begin
      n_start[k] = 0; n_done[k] = 0; dly[k] = 3; last_resp[k] = -1; last_start[k] = -1;
      mval[k] = '0;
    end
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      chk("reset_tx_start", tx_start_w[k], 1'b0);
      chk("reset_tx_data", tx_data_w[k], 8'h00);
      chk("reset_busy", busy_w[k], 1'b0);
      chk("reset_done", done_w[k], 1'b0);
    end
    rst = 1'b1;
    repeat (2) step();

    dump(0, 20'hABCDE, 5, 0);
    chk("basic_first_byte", cap[0][0], 8'h0A);
    dump(0, 20'hABCDE, 5, 1);
    dump(0, 20'hABCDE, 4, 2);

    spur[0] = 1'b1; step(); spur[0] = 1'b0; repeat (2) step();
    chk("idle_spur_no_start", n_start[0], 3);
    chk("idle_spur_busy", busy_w[0], 1'b0);
    dump(0, 20'hABCDE, 5, 4);

    n_start[0] = 0; bus_a = 20'hABCDE; dly[0] = 5;
    start_w[0] = 1'b1; step(); start_w[0] = 1'b0;
    for (int i = 0; i < 100 && n_start[0] < 2; i++) begin
      @(negedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    chk("abort_tx_start", tx_start_w[0], 1'b0);
    chk("abort_tx_data", tx_data_w[0], 8'h00);
    chk("abort_busy", busy_w[0], 1'b0);
    chk("abort_done", done_w[0], 1'b0);
    step(); repeat (2) step();
    rst = 1'b1;
    repeat (5) step();
    chk("abort_no_more_start", n_start[0], 2);
    chk("abort_idle_busy", busy_w[0], 1'b0);
    chk("abort_idle_data", tx_data_w[0], 8'h00);
    dump(0, 20'h00001, 3, 0);

    v = '0;
    for (int i = 0; i < 203; i++) v[8 * (202 - i) +: 8] = 8'(i);
    dump(1, v, int'($urandom_range(2, 6)), 0);
    chk("wide_last_byte", cap[1][202], 8'hCA);

    dump(2, 8'hFF, 3, 0);

    for (int r = 0; r < 4; r++) begin
      v = '0; v[19:0] = 20'($urandom);
      dump(0, v, int'($urandom_range(2, 6)), int'($urandom_range(0, 7)));
    end
    for (int r = 0; r < 3; r++) begin
      v = '0; v[7:0] = 8'($urandom);
      dump(2, v, int'($urandom_range(2, 6)), int'($urandom_range(0, 7)));
    end

    v = '0; v[19:0] = 20'($urandom);
    fall_cyc[0] = -1; n_start[0] = 0; mval[0] = v; bus_a = v[19:0]; dly[0] = 3;
    start_w[0] = 1'b1;
    pf = -1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 200 && fall_cyc[0] == pf; i++) step();
      pf = fall_cyc[0];
      for (int i = 0; i < 10 && last_start[0] <= pf; i++) step();
      chk("held_start_restart", last_start[0], pf + 1);
    end
    start_w[0] = 1'b0;
    for (int i = 0; i < 200 && fall_cyc[0] == pf; i++) step();
    chk("held_final_idle", busy_w[0], 1'b0);
    for (int i = 0; i < 9; i++) chk($sformatf("held_byte%0d", i), cap[0][i], exp_byte(0, i % 3));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
